// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants, framebuffer geometry and pixel types shared by the scanout blocks
package vga_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCALE_SHIFT = 1;
    localparam int RD_LAT      = 2;
    localparam int ADDR_W      = 18;
    localparam int FB_W        = 320;
    localparam int FB_H        = 240;
    localparam int FB_WORDS    = FB_W * FB_H;
    localparam int CNT_W       = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters plus the strobes derived from them (active, raw syncs, frame start, swap point)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             CLK25MHZ,
    input  logic             ck_rst_,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_n,
    output logic             vs_n,
    output logic             frame_start,
    output logic             line_end,
    output logic             frame_end,
    output logic             swap_pt
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    // next raster position: h wraps every line, v advances on h wrap and wraps every frame
    always_comb begin
        line_end  = h_cnt_q == CNT_W'(HT - 1);
        frame_end = line_end && v_cnt_q == CNT_W'(VT - 1);
        h_cnt_d   = line_end ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d   = frame_end ? '0 : line_end ? v_cnt_q + CNT_W'(1) : v_cnt_q;
    end

    // raster position registers
    always_ff @(posedge CLK25MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign active      = h_cnt_q < CNT_W'(H_ACTIVE) && v_cnt_q < CNT_W'(V_ACTIVE);
    assign hs_n        = !(h_cnt_q >= CNT_W'(H_ACTIVE + H_FP) && h_cnt_q < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_n        = !(v_cnt_q >= CNT_W'(V_ACTIVE + V_FP) && v_cnt_q < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    // gated by reset so the pulse is low while held in reset, yet high on the very first cycle after release
    assign frame_start = ck_rst_ && h_cnt_q == '0 && v_cnt_q == '0;
    assign swap_pt     = line_end && v_cnt_q == CNT_W'(V_ACTIVE - 1);
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: double-buffered 2x-upscaled framebuffer scanout with tear-free buffer swaps
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter int RD_LAT      = vga_pkg::RD_LAT,
    parameter int ADDR_W      = vga_pkg::ADDR_W
) (
    input  logic              CLK25MHZ,
    input  logic              ck_rst_,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [11:0]       fb_rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              frame_start,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs
);
    localparam int ROW_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int BUF_WORDS = ROW_W * (V_ACTIVE >> SCALE_SHIFT);
    localparam logic [CNT_W-1:0] V_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

    logic [CNT_W-1:0]  h_cnt, v_cnt;
    logic              active, hs_n, vs_n, line_end, frame_end, swap_pt, do_swap;
    logic [ADDR_W-1:0] row_base_q, row_base_d, fb_rd_addr_q, fb_rd_addr_d;
    logic              fb_rd_en_q, fb_rd_en_d, front_buf_q, front_buf_d, pending_q, pending_d;
    logic [RD_LAT:0]   act_pipe_q, act_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
    rgb12_t            rgb_q, rgb_d;
    logic              hs_q, hs_d, vs_q, vs_d;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .CLK25MHZ   (CLK25MHZ),
        .ck_rst_    (ck_rst_),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .frame_start(frame_start),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .swap_pt    (swap_pt)
    );

    // swap arbitration, incremental row addressing and the data-aligned control/sync delay line
    always_comb begin
        do_swap      = swap_pt && (pending_q || swap_req);
        pending_d    = !do_swap && (pending_q || swap_req);
        front_buf_d  = front_buf_q ^ do_swap;
        row_base_d   = frame_end ? '0
                     : (line_end && (v_cnt & V_MASK) == V_MASK) ? row_base_q + ADDR_W'(ROW_W)
                     : row_base_q;
        fb_rd_en_d   = active;
        fb_rd_addr_d = active ? (front_buf_q ? ADDR_W'(BUF_WORDS) : '0) + row_base_q + ADDR_W'(h_cnt >> SCALE_SHIFT)
                     : fb_rd_addr_q;
        act_pipe_d   = {act_pipe_q[RD_LAT-1:0], active};
        hs_pipe_d    = {hs_pipe_q[RD_LAT-1:0], hs_n};
        vs_pipe_d    = {vs_pipe_q[RD_LAT-1:0], vs_n};
        rgb_d        = act_pipe_q[RD_LAT] ? rgb12_t'(fb_rd_data) : '0;
        hs_d         = hs_pipe_q[RD_LAT];
        vs_d         = vs_pipe_q[RD_LAT];
    end

    // all state; reset leaves the pipeline blank with syncs inactive
    always_ff @(posedge CLK25MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            row_base_q   <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= '0;
            front_buf_q  <= 1'b0;
            pending_q    <= 1'b0;
            act_pipe_q   <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            row_base_q   <= row_base_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            front_buf_q  <= front_buf_d;
            pending_q    <= pending_d;
            act_pipe_q   <= act_pipe_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    // ack is combinational so a controller dropping swap_req on it never leaves a stray pending request
    assign swap_ack   = do_swap;
    assign front_buf  = front_buf_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_rd_addr = fb_rd_addr_q;
    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
endmodule
